// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives the count controls; the slave (the counter) returns count and flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] counter_out;
    logic             tc;
    logic             wrap_pulse;

    modport master (
        output enable,
        output up_down,
        output load,
        output load_value,
        input  counter_out,
        input  tc,
        input  wrap_pulse
    );

    modport slave (
        input  enable,
        input  up_down,
        input  load,
        input  load_value,
        output counter_out,
        output tc,
        output wrap_pulse
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with range 0..MAX_COUNT, synchronous load, wrap or saturate ends.
// Optional tick prescaler enabled by defining CNT_PRESCALE_EN.
module updown_mod_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0,
    parameter int PRESCALE  = 4
) (
    input logic                 clock,
    input logic                 reset,
    updown_mod_counter_if.slave cnt
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_q;
    logic             wrap_d;
    logic             step;
    logic             at_max;
    logic             at_zero;

`ifdef CNT_PRESCALE_EN
    localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;

    // Phase restarts on load so the first step after a load is a full period away.
    always_ff @(posedge clock) begin
        if (reset || cnt.load) begin
            ps_q <= '0;
        end else if (cnt.enable) begin
            ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
        end
    end

    assign step = cnt.enable && (ps_q == PS_LAST);
`else
    logic [31:0] unused_prescale;

    assign unused_prescale = PRESCALE;
    assign step            = cnt.enable;
`endif

    assign at_max       = (count_q == MAX_VAL);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (cnt.load_value > MAX_VAL) ? MAX_VAL : cnt.load_value;

    // Increments only happen below MAX_VAL and decrements only above zero,
    // so the result never leaves 0..MAX_COUNT.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (cnt.load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (cnt.up_down) begin
                if (!at_max) begin
                    count_d = count_q + 1'b1;
                end else if (SATURATE == 0) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - 1'b1;
                end else if (SATURATE == 0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt.counter_out = count_q;
    assign cnt.wrap_pulse  = wrap_q;
    assign cnt.tc          = cnt.up_down ? at_max : at_zero;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (wrap/7, wrap/5, saturate/7) share one stimulus
// and are checked against an arithmetic reference model plus directed expectations.
module tb_updown_mod_counter;
    localparam int PRESCALE = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [2:0] load_value;

    logic [2:0] cnt_o  [3];
    logic       tc_o   [3];
    logic       wrap_o [3];

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt  [3];
    int m_wrap [3];
    int m_ps   [3];
    int m_max  [3] = '{7, 5, 7};
    int m_sat  [3] = '{0, 0, 1};

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        updown_mod_counter_if #(.WIDTH(3)) bus ();

        assign bus.enable     = enable;
        assign bus.up_down    = up_down;
        assign bus.load       = load;
        assign bus.load_value = load_value;
        assign cnt_o[g]       = bus.counter_out;
        assign tc_o[g]        = bus.tc;
        assign wrap_o[g]      = bus.wrap_pulse;

        updown_mod_counter #(
            .WIDTH    (3),
            .MAX_COUNT((g == 1) ? 5 : 7),
            .SATURATE ((g == 2) ? 1 : 0),
            .PRESCALE (PRESCALE)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .cnt  (bus)
        );
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic int exp_tc(input int k);
        if (up_down) return (m_cnt[k] == m_max[k]) ? 1 : 0;
        return (m_cnt[k] == 0) ? 1 : 0;
    endfunction

    // Reference: next value from plain integer arithmetic on the range 0..max.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit do_step;
            do_step   = 1'b0;
            m_wrap[k] = 0;
            if (reset) begin
                m_cnt[k] = 0;
                m_ps[k]  = 0;
            end else if (load) begin
                m_cnt[k] = (int'(load_value) > m_max[k]) ? m_max[k] : int'(load_value);
                m_ps[k]  = 0;
            end else if (enable) begin
`ifdef CNT_PRESCALE_EN
                m_ps[k]++;
                do_step = (m_ps[k] % PRESCALE) == 0;
`else
                do_step = 1'b1;
`endif
            end
            if (do_step) begin
                int nxt;
                nxt = up_down ? m_cnt[k] + 1 : m_cnt[k] - 1;
                if (nxt > m_max[k]) begin
                    if (m_sat[k] == 0) begin
                        m_cnt[k]  = 0;
                        m_wrap[k] = 1;
                    end
                end else if (nxt < 0) begin
                    if (m_sat[k] == 0) begin
                        m_cnt[k]  = m_max[k];
                        m_wrap[k] = 1;
                    end
                end else begin
                    m_cnt[k] = nxt;
                end
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clock);
        for (int k = 0; k < 3; k++) chk({tag, "/tc_pre"}, k, 32'(tc_o[k]), exp_tc(k));
        @(posedge clock);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "/cnt"},  k, 32'(cnt_o[k]),  m_cnt[k]);
            chk({tag, "/wrap"}, k, 32'(wrap_o[k]), m_wrap[k]);
            chk({tag, "/tc"},   k, 32'(tc_o[k]),   exp_tc(k));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            m_wrap[k] = 0;
            m_ps[k]   = 0;
        end
        reset      = 1'b1;
        enable     = 1'b0;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 3'd0;
        cycle("reset");
        chk("reset_cnt", 0, 32'(cnt_o[0]), 0);
        chk("reset_tc_up", 0, 32'(tc_o[0]), 0);

`ifndef CNT_PRESCALE_EN
        begin
            int seq [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
            reset  = 1'b0;
            enable = 1'b1;
            for (int i = 0; i < 10; i++) begin
                cycle("t1_up");
                chk("t1_seq", 0, 32'(cnt_o[0]), seq[i]);
                chk("t1_wrap", 0, 32'(wrap_o[0]), (i == 7) ? 1 : 0);
                chk("t1_tc", 0, 32'(tc_o[0]), (seq[i] == 7) ? 1 : 0);
            end
        end

        begin
            int seq [7] = '{5, 4, 3, 2, 1, 0, 5};
            reset = 1'b1;
            cycle("t2_rst");
            reset   = 1'b0;
            up_down = 1'b0;
            #1 chk("t2_tc_at0", 1, 32'(tc_o[1]), 1);
            for (int i = 0; i < 7; i++) begin
                cycle("t2_down");
                chk("t2_seq", 1, 32'(cnt_o[1]), seq[i]);
                chk("t2_wrap", 1, 32'(wrap_o[1]), (i == 0 || i == 6) ? 1 : 0);
            end
            load       = 1'b1;
            load_value = 3'd7;
            cycle("t2_load");
            chk("t2_clamp", 1, 32'(cnt_o[1]), 5);
            chk("t2_noclamp", 0, 32'(cnt_o[0]), 7);
        end

        load_value = 3'd6;
        cycle("t3_load6");
        load    = 1'b0;
        up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("t3_sat");
            chk("t3_hold7", 2, 32'(cnt_o[2]), 7);
            chk("t3_nowrap", 2, 32'(wrap_o[2]), 0);
        end
        chk("t3_tc_up", 2, 32'(tc_o[2]), 1);
        up_down = 1'b0;
        #1 chk("t3_tc_drop", 2, 32'(tc_o[2]), 0);
        cycle("t3_dn");
        chk("t3_dn6", 2, 32'(cnt_o[2]), 6);
        cycle("t3_dn");
        chk("t3_dn5", 2, 32'(cnt_o[2]), 5);

        load       = 1'b1;
        enable     = 1'b1;
        load_value = 3'd3;
        cycle("t4_ld_en");
        chk("t4_ld_nostep", 0, 32'(cnt_o[0]), 3);
        reset = 1'b1;
        cycle("t4_rst_ld");
        chk("t4_rst_wins", 0, 32'(cnt_o[0]), 0);
        reset   = 1'b0;
        load    = 1'b0;
        up_down = 1'b1;
        for (int i = 0; i < 4; i++) cycle("t4_count");
        chk("t4_at4", 0, 32'(cnt_o[0]), 4);
        reset = 1'b1;
        cycle("t4_midrst");
        chk("t4_rst0", 0, 32'(cnt_o[0]), 0);
        reset = 1'b0;
`else
        reset   = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle("t5_ps");
            if (i % 4 == 0) chk("t5_step", 0, 32'(cnt_o[0]), i / 4);
        end
        enable = 1'b0;
        cycle("t5_pause");
        cycle("t5_pause");
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle("t5_run");
        chk("t5_delayed", 0, 32'(cnt_o[0]), 3);
        cycle("t5_run");
        chk("t5_step4", 0, 32'(cnt_o[0]), 4);
        load       = 1'b1;
        load_value = 3'd1;
        cycle("t5_load");
        load = 1'b0;
        for (int i = 0; i < 3; i++) cycle("t5_after_ld");
        chk("t5_phase_hold", 0, 32'(cnt_o[0]), 1);
        cycle("t5_after_ld");
        chk("t5_phase_step", 0, 32'(cnt_o[0]), 2);
`endif

        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 19) == 0);
            load       = ($urandom_range(0, 7) == 0);
            enable     = ($urandom_range(0, 3) != 0);
            up_down    = $urandom_range(0, 1) != 0;
            load_value = 3'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
